sipo_deser: RTL and testbench
=============================

# sipo_deser

Serial-in parallel-out deserializer that sits directly downstream of the 4-bit PISO shift register. It samples a qualified serial bit stream, assembles WIDTH-bit words under start-of-frame framing, and presents each completed word on a registered parallel output with a valid/ready handshake. A separate output holding register lets the shifter keep assembling the next frame while the consumer stalls. Overflow and, optionally, parity errors are reported.

## Interface
Parameters:
- WIDTH, 4: data bits per frame, minimum 2; the default matches the PISO word.
- MSB_FIRST, 1: 1 = first serial bit lands in pout[WIDTH-1], which matches PISO ordering (d3 first); 0 = first bit lands in pout[0].

Ports:
- clk  in  1  rising-edge clock; the block uses only this one clock.
- rst_n  in  1  asynchronous, active-low reset.
- sin  in  1  serial data bit.
- sin_vld  in  1  sin is sampled only on edges where this is 1.
- sof  in  1  start of frame; qualified by sin_vld; the bit accompanying it is data bit 0 of a new frame.
- pout  out  WIDTH  assembled word; stable while pout_vld=1.
- pout_vld  out  1  the output register holds an unconsumed word.
- pout_rdy  in  1  the consumer accepts pout on an edge where pout_vld && pout_rdy.
- busy  out  1  a frame is partially assembled (state ≠ IDLE).
- ovf  out  1  sticky: a completed word was dropped because the output register was full.
- ovf_clr  in  1  synchronous clear of ovf.
- perr  out  1  one-cycle pulse: parity mismatch, word dropped; tied to 0 without SIPO_PARITY_EN.

## Operation
- Reset values: pout=0, pout_vld=0, busy=0, ovf=0, perr=0; state=IDLE, bit counter=0, shifter=0.
- FSM states:
  - IDLE: bits without sof are ignored. sin_vld&&sof → capture the bit, cnt=1, go to SHIFT.
  - SHIFT: each sin_vld captures one bit and increments cnt. When the WIDTH-th bit is captured, the frame completes and the FSM goes to IDLE; with SIPO_PARITY_EN it goes to PAR instead.
  - PAR (macro only): the next sin_vld bit is the parity bit. The frame completes, then the FSM goes to IDLE.
- sof with sin_vld in SHIFT or PAR discards the partial frame. That bit becomes bit 0 of a new frame, cnt=1, state=SHIFT. No error is flagged.
- sin_vld=0 holds all state; there is no timeout.
- Frame completion, same edge that captures the final bit:
  - Output empty, or pout_rdy=1 on that edge: load pout with the word, pout_vld=1.
  - Output full and pout_rdy=0: drop the word, set ovf=1; pout and pout_vld are unchanged.
- Handshake: pout_vld&&pout_rdy with no completion on the same edge → pout_vld=0. pout holds its last value.
- ovf_clr and a new overflow on the same edge: the set wins, so ovf=1.
- A sof bit arriving on the same edge as a completion is impossible: completion requires the final bit, and sof restarts instead. The restart takes priority.

## Timing
- One bit is accepted per clock at most; back-to-back frames with sin_vld held high are supported with no gap cycles.
- Latency: pout_vld is high in the cycle immediately after the edge that captures the final data bit (or the parity bit).
- The output register decouples the stages: one full frame can be assembled while a word is stalled. Overflow occurs only when a second frame completes before the first is consumed.
- perr asserts in the cycle after the parity bit edge and lasts exactly one cycle.
- Asserting rst_n low mid-frame clears everything immediately, including a pending pout_vld word. The first frame after release must start with sof.

## Configuration
- SIPO_PARITY_EN defined:
  - Each frame is WIDTH data bits plus one even-parity bit.
  - Completion occurs in PAR.
  - A word whose data XOR parity is not 0 is dropped: no load, perr=1 for one cycle, ovf unaffected.
- SIPO_PARITY_EN undefined:
  - There is no PAR state; a frame is exactly WIDTH bits.
  - perr is driven constant 0.

## Test plan
- Reset, then with WIDTH=4, MSB_FIRST=1, pout_rdy=1, send sof + bits 1,0,1,1 on consecutive edges → pout=4'b1011, pout_vld high for exactly one cycle, busy low afterwards.
- pout_rdy=0, send two frames, 4'hA then 4'h5 → pout=4'hA held, ovf=1 after the second frame completes. Then raise pout_rdy → pout_vld drops, ovf stays 1 until ovf_clr.
- Send sof + 1,1, then sof + 0,0,1,1 → pout=4'b0011 only; no word is produced for the aborted frame.
- sin_vld toggling 1,0,1,0… across frame 4'h6 → pout=4'h6 after the 4th qualified bit; non-qualified cycles are ignored.
- Assert rst_n low in the middle of a frame and while pout_vld=1 → all outputs are 0 asynchronously. Bits without sof after release produce no word.
- With SIPO_PARITY_EN: 4'b1011 + parity 1 → pout=4'hB. 4'b1011 + parity 0 → no pout_vld, perr pulses once.

Source files
------------

// File: rtl/sipo_deser.sv
// sipo_deser: serial-in parallel-out deserializer with start-of-frame framing,
// a registered valid/ready output stage, sticky overflow and optional parity.
// Optional feature macro: SIPO_PARITY_EN (adds an even-parity bit per frame,
// a PAR state and the perr pulse; without it perr is tied low).
module sipo_deser #(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sin,
    input  logic             sin_vld,
    input  logic             sof,
    output logic [WIDTH-1:0] pout,
    output logic             pout_vld,
    input  logic             pout_rdy,
    output logic             busy,
    output logic             ovf,
    input  logic             ovf_clr,
    output logic             perr
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
`ifdef SIPO_PARITY_EN
        S_PAR   = 2'd2,
`endif
        S_SHIFT = 2'd1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_shift_nxt;
    logic [WIDTH-1:0] w_shift_in;
    logic             w_complete;
    logic [WIDTH-1:0] w_word;
    logic [WIDTH-1:0] r_pout;
    logic             r_pout_vld;
    logic             r_ovf;
`ifdef SIPO_PARITY_EN
    logic             w_perr_set;
    logic             r_perr;
`endif

    // Shifter contents after capturing sin; the bit order sets where bit 0 lands.
    assign w_shift_in = MSB_FIRST ? {r_shift[WIDTH-2:0], sin}
                                  : {sin, r_shift[WIDTH-1:1]};

    // FSM state, bit counter and shifter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_shift <= w_shift_nxt;
        end
    end

    // Next-state logic; sof restarts the frame ahead of any completion.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shift_nxt = r_shift;
        w_complete  = 1'b0;
        w_word      = r_shift;
`ifdef SIPO_PARITY_EN
        w_perr_set  = 1'b0;
`endif
        if (sin_vld) begin
            if (sof) begin
                w_shift_nxt = w_shift_in;
                w_cnt_nxt   = CW'(1);
                w_state_nxt = S_SHIFT;
            end else begin
                case (r_state)
                    S_SHIFT: begin
                        w_shift_nxt = w_shift_in;
                        if (r_cnt == CW'(WIDTH - 1)) begin
                            w_cnt_nxt = '0;
`ifdef SIPO_PARITY_EN
                            w_state_nxt = S_PAR;
`else
                            w_state_nxt = S_IDLE;
                            w_complete  = 1'b1;
                            w_word      = w_shift_in;
`endif
                        end else begin
                            w_cnt_nxt = r_cnt + 1'b1;
                        end
                    end
`ifdef SIPO_PARITY_EN
                    S_PAR: begin
                        w_state_nxt = S_IDLE;
                        if (^{r_shift, sin}) begin
                            w_perr_set = 1'b1;
                        end else begin
                            w_complete = 1'b1;
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    // Output holding register, handshake and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pout     <= '0;
            r_pout_vld <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            if (w_complete && (!r_pout_vld || pout_rdy)) begin
                r_pout     <= w_word;
                r_pout_vld <= 1'b1;
            end else if (r_pout_vld && pout_rdy) begin
                r_pout_vld <= 1'b0;
            end
            if (w_complete && r_pout_vld && !pout_rdy) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

`ifdef SIPO_PARITY_EN
    // One-cycle parity error pulse following the parity bit edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perr <= 1'b0;
        end else begin
            r_perr <= w_perr_set;
        end
    end
    assign perr = r_perr;
`else
    assign perr = 1'b0;
`endif

    assign pout     = r_pout;
    assign pout_vld = r_pout_vld;
    assign ovf      = r_ovf;
    assign busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_sipo_deser.sv
// Directed bench for sipo_deser in its default build (WIDTH=4, MSB first).
module tb_sipo_deser;

    logic       clk;
    logic       rst_n;
    logic       sin;
    logic       sin_vld;
    logic       sof;
    logic [3:0] pout;
    logic       pout_vld;
    logic       pout_rdy;
    logic       busy;
    logic       ovf;
    logic       ovf_clr;
    logic       perr;

    int checks   = 0;
    int failures = 0;

    sipo_deser #(.WIDTH(4), .MSB_FIRST(1'b1)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sin      (sin),
        .sin_vld  (sin_vld),
        .sof      (sof),
        .pout     (pout),
        .pout_vld (pout_vld),
        .pout_rdy (pout_rdy),
        .busy     (busy),
        .ovf      (ovf),
        .ovf_clr  (ovf_clr),
        .perr     (perr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply inputs, let one rising edge pass, sample 1 time unit after it.
    task automatic step(input logic v, input logic s, input logic b);
        sin_vld = v;
        sof     = s;
        sin     = b;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        sin      = 1'b0;
        sin_vld  = 1'b0;
        sof      = 1'b0;
        pout_rdy = 1'b1;
        ovf_clr  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pout", 32'(pout), 32'h0);
        chk("rst_vld", 32'(pout_vld), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_ovf", 32'(ovf), 32'h0);
        chk("rst_perr", 32'(perr), 32'h0);
        rst_n = 1'b1;
        step(0, 0, 0);

        // Basic frame 1011 with consumer ready
        step(1, 1, 1);
        chk("t1_busy_mid", 32'(busy), 32'h1);
        step(1, 0, 0);
        step(1, 0, 1);
        chk("t1_vld_early", 32'(pout_vld), 32'h0);
        step(1, 0, 1);
        chk("t1_pout", 32'(pout), 32'hB);
        chk("t1_vld", 32'(pout_vld), 32'h1);
        chk("t1_busy_done", 32'(busy), 32'h0);
        step(0, 0, 0);
        chk("t1_vld_one_cycle", 32'(pout_vld), 32'h0);
        chk("t1_pout_hold", 32'(pout), 32'hB);

        // Stall: A then 5 back to back, second is dropped
        pout_rdy = 1'b0;
        step(1, 1, 1); step(1, 0, 0); step(1, 0, 1); step(1, 0, 0);
        chk("t2_first_pout", 32'(pout), 32'hA);
        chk("t2_first_vld", 32'(pout_vld), 32'h1);
        chk("t2_no_ovf_yet", 32'(ovf), 32'h0);
        step(1, 1, 0); step(1, 0, 1); step(1, 0, 0); step(1, 0, 1);
        chk("t2_ovf", 32'(ovf), 32'h1);
        chk("t2_pout_held", 32'(pout), 32'hA);
        chk("t2_vld_held", 32'(pout_vld), 32'h1);
        pout_rdy = 1'b1;
        step(0, 0, 0);
        chk("t2_vld_drop", 32'(pout_vld), 32'h0);
        chk("t2_ovf_sticky", 32'(ovf), 32'h1);
        ovf_clr = 1'b1;
        step(0, 0, 0);
        ovf_clr = 1'b0;
        chk("t2_ovf_clr", 32'(ovf), 32'h0);

        // Aborted frame followed by sof restart with 0011
        step(1, 1, 1); step(1, 0, 1);
        step(1, 1, 0); step(1, 0, 0); step(1, 0, 1);
        chk("t3_no_abort_word", 32'(pout_vld), 32'h0);
        chk("t3_busy", 32'(busy), 32'h1);
        step(1, 0, 1);
        chk("t3_pout", 32'(pout), 32'h3);
        chk("t3_vld", 32'(pout_vld), 32'h1);
        step(0, 0, 0);

        // sin_vld toggling across 0110; unqualified cycles carry junk
        step(1, 1, 0); step(0, 1, 1);
        step(1, 0, 1); step(0, 1, 0);
        step(1, 0, 1); step(0, 0, 0);
        chk("t4_vld_early", 32'(pout_vld), 32'h0);
        step(1, 0, 0);
        chk("t4_pout", 32'(pout), 32'h6);
        chk("t4_vld", 32'(pout_vld), 32'h1);
        step(0, 0, 0);

        // Asynchronous reset with a stalled word and a partial frame
        pout_rdy = 1'b0;
        step(1, 1, 1); step(1, 0, 1); step(1, 0, 1); step(1, 0, 1);
        chk("t5_pre_pout", 32'(pout), 32'hF);
        step(1, 1, 1); step(1, 0, 0);
        chk("t5_pre_busy", 32'(busy), 32'h1);
        sin_vld = 1'b0;
        sof     = 1'b0;
        rst_n   = 1'b0;
        #2;
        chk("t5_async_pout", 32'(pout), 32'h0);
        chk("t5_async_vld", 32'(pout_vld), 32'h0);
        chk("t5_async_busy", 32'(busy), 32'h0);
        @(negedge clk);
        rst_n    = 1'b1;
        pout_rdy = 1'b1;
        step(1, 0, 1); step(1, 0, 0); step(1, 0, 1); step(1, 0, 1);
        chk("t5_no_sof_vld", 32'(pout_vld), 32'h0);
        chk("t5_no_sof_busy", 32'(busy), 32'h0);
        step(1, 1, 1); step(1, 0, 0); step(1, 0, 0); step(1, 0, 1);
        chk("t5_recover_pout", 32'(pout), 32'h9);
        chk("t5_recover_vld", 32'(pout_vld), 32'h1);
        chk("perr_tied", 32'(perr), 32'h0);
        step(0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
